// File: rtl/data_transfer_d_ctrl_pkg.sv
// data_transfer_pkg
//   Shared encodings for the LEGv8 D-format (data-transfer) decoder:
//   opcode constants, ALU function select, mem_size / wb_sel / pc_sel
//   encodings, the 96-bit datapath control word layout and an
//   immediate sign-extension helper.
//   The byte-wide opcodes are only decoded when DATA_TRANSFER_BYTE_EN
//   is defined (see dt_decode).
package data_transfer_pkg;

    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STURB = 11'b00111000000;
    localparam logic [10:0] OP_LDURB = 11'b00111000010;

    localparam logic [4:0] ALU_ADD = 5'b01000;

    localparam logic [1:0] MEM_SIZE_BYTE  = 2'b00;
    localparam logic [1:0] MEM_SIZE_DWORD = 2'b11;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;

    // Control word, MSB first; total width 96 bits.
    typedef struct packed {
        logic [4:0]  rd_addr_a;  // Rn, base address register
        logic [4:0]  rd_addr_b;  // Rt, store data register
        logic [4:0]  wr_addr;    // Rt, load destination
        logic        reg_write;
        logic        mem_write;
        logic        mem_read;
        logic [1:0]  mem_size;
        logic [4:0]  alu_fs;
        logic        b_sel_imm;
        logic [1:0]  wb_sel;
        logic [1:0]  pc_sel;
        logic        set_flags;
        logic        valid;
        logic [63:0] imm;
    } ctrl_word_t;

    // dt_addr is a signed 9-bit byte offset.
    function automatic logic [63:0] sext_dt_addr(input logic [8:0] dt_addr);
        return {{55{dt_addr[8]}}, dt_addr};
    endfunction

endpackage

// File: rtl/data_transfer_d_ctrl_dt_decode.sv
// dt_decode
//   Purely combinational D-format decoder: instruction word in, next
//   control word out. Unrecognised opcodes yield an all-zero word
//   (valid=0, no register or memory side effects).
//   Optional feature macro: DATA_TRANSFER_BYTE_EN adds STURB/LDURB
//   (byte-sized accesses); without it those opcodes are NOPs.
// Ports:
//   instr      in  32  instruction word
//   ctrl_next  out 96  decoded control word (unregistered)
module dt_decode
    import data_transfer_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_word_t  ctrl_next
);

    logic [10:0] opcode;
    logic [8:0]  dt_addr;
    logic [4:0]  rn;
    logic [4:0]  rt;
    logic        unused_op2;

    assign opcode     = instr[31:21];
    assign dt_addr    = instr[20:12];
    assign rn         = instr[9:5];
    assign rt         = instr[4:0];
    // op2 carries no meaning for these instructions.
    assign unused_op2 = ^instr[11:10];

    logic       hit;
    logic       is_load;
    logic [1:0] size;

    always_comb begin
        hit     = 1'b0;
        is_load = 1'b0;
        size    = MEM_SIZE_DWORD;
        case (opcode)
            OP_STUR: begin
                hit = 1'b1;
            end
            OP_LDUR: begin
                hit     = 1'b1;
                is_load = 1'b1;
            end
`ifdef DATA_TRANSFER_BYTE_EN
            OP_STURB: begin
                hit  = 1'b1;
                size = MEM_SIZE_BYTE;
            end
            OP_LDURB: begin
                hit     = 1'b1;
                is_load = 1'b1;
                size    = MEM_SIZE_BYTE;
            end
`endif
            default: begin
                hit = 1'b0;
            end
        endcase
    end

    always_comb begin
        ctrl_next = '0;
        // Everything, including addresses and imm, stays zero on a miss.
        if (hit) begin
            ctrl_next.rd_addr_a = rn;
            ctrl_next.rd_addr_b = rt;
            ctrl_next.wr_addr   = rt;
            ctrl_next.reg_write = is_load;
            ctrl_next.mem_write = ~is_load;
            ctrl_next.mem_read  = is_load;
            ctrl_next.mem_size  = size;
            ctrl_next.alu_fs    = ALU_ADD;
            ctrl_next.b_sel_imm = 1'b1;
            ctrl_next.wb_sel    = is_load ? WB_SEL_MEM : WB_SEL_ALU;
            ctrl_next.pc_sel    = PC_SEL_PLUS4;
            ctrl_next.set_flags = 1'b0;
            ctrl_next.valid     = 1'b1;
            ctrl_next.imm       = sext_dt_addr(dt_addr);
        end
    end

endmodule

// File: rtl/data_transfer_d_ctrl.sv
// data_transfer_d_ctrl
//   Registered control-word decoder for LEGv8 D-format instructions
//   (LDUR/STUR, plus LDURB/STURB when DATA_TRANSFER_BYTE_EN is defined).
//   One-cycle latency, a new instruction every cycle. There is no
//   valid/ready handshake: the instruction is always accepted and the
//   word's own valid bit marks whether it decoded to a real operation.
// Ports:
//   clk        in  1   rising-edge clock
//   rst_n      in  1   asynchronous active-low reset (clears ctrl_word)
//   instr      in  32  instruction word
//   ctrl_word  out 96  registered control word
module data_transfer_d_ctrl
    import data_transfer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    output logic [95:0] ctrl_word
);

    ctrl_word_t dec_word;
    ctrl_word_t ctrl_word_d;
    ctrl_word_t ctrl_word_q;

    dt_decode u_dt_decode (
        .instr     (instr),
        .ctrl_next (dec_word)
    );

    always_comb begin
        ctrl_word_d = dec_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_word_q <= '0;
        end else begin
            ctrl_word_q <= ctrl_word_d;
        end
    end

    assign ctrl_word = ctrl_word_q;

endmodule

// File: tb/tb_data_transfer_d_ctrl.sv
// tb_data_transfer_d_ctrl
//   Directed, table-driven bench for data_transfer_d_ctrl. Expected
//   control words are built from hand-decoded field values.
//   Honors DATA_TRANSFER_BYTE_EN for the byte-op expectations.
module tb_data_transfer_d_ctrl;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [95:0] ctrl_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    data_transfer_d_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .instr     (instr),
        .ctrl_word (ctrl_word)
    );

    // ---------------- scoreboard ----------------
    int          n_vec;
    int          n_err;
    logic [95:0] exp_q[$];

    // Assemble a valid D-format word from field values
    // (alu_fs=01000, b_sel_imm=1, pc_sel=00, set_flags=0, valid=1).
    function automatic logic [95:0] dt_word(
        input logic [4:0]  rn,
        input logic [4:0]  rt,
        input logic        rw,
        input logic        mw,
        input logic        mr,
        input logic [1:0]  size,
        input logic [1:0]  wb,
        input logic [63:0] imm
    );
        return {rn, rt, rt, rw, mw, mr, size, 5'b01000, 1'b1, wb,
                2'b00, 1'b0, 1'b1, imm};
    endfunction

    task automatic check(input string name, input logic [95:0] exp);
        n_vec++;
        if (ctrl_word !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, ctrl_word, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Drive instr between edges, confirm the output has not moved yet,
    // then sample one cycle later.
    task automatic apply(input string name, input logic [31:0] ins,
                         input logic [95:0] exp, input logic [95:0] prev);
        instr = ins;
        exp_q.push_back(exp);
        #1;
        check({name, "_hold"}, prev);
        @(posedge clk);
        #1;
        check(name, exp_q.pop_front());
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [95:0] exp;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    localparam logic [63:0] IMM_M256 = 64'hFFFF_FFFF_FFFF_FF00;

    initial begin
        logic [95:0] prev;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{"stur_neg",   32'hF810_0008, dt_word(5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, IMM_M256)};
        vecs[1]  = '{"ldur_neg",   32'hF850_0004, dt_word(5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, IMM_M256)};
        vecs[2]  = '{"ldur_pos",   32'hF840_8043, dt_word(5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, 64'd8)};
`ifdef DATA_TRANSFER_BYTE_EN
        vecs[3]  = '{"sturb",      32'h3810_0001, dt_word(5'd0, 5'd1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, IMM_M256)};
        vecs[4]  = '{"ldurb",      32'h3850_0002, dt_word(5'd0, 5'd2, 1'b1, 1'b0, 1'b1, 2'b00, 2'b01, IMM_M256)};
`else
        vecs[3]  = '{"sturb",      32'h3810_0001, 96'h0};
        vecs[4]  = '{"ldurb",      32'h3850_0002, 96'h0};
`endif
        vecs[5]  = '{"add_nop",    32'h8B02_0020, 96'h0};
        vecs[6]  = '{"stur_max",   {11'b11111000000, 9'h0FF, 2'b00, 5'd31, 5'd31},
                     dt_word(5'd31, 5'd31, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 64'h0000_0000_0000_00FF)};
        vecs[7]  = '{"ldur_xzr",   {11'b11111000010, 9'h100, 2'b11, 5'd5, 5'd31},
                     dt_word(5'd5, 5'd31, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, IMM_M256)};
        vecs[8]  = '{"b2b_stur0",  32'hF810_0008, dt_word(5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, IMM_M256)};
        vecs[9]  = '{"b2b_ldur",   32'hF850_0004, dt_word(5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, IMM_M256)};
        vecs[10] = '{"b2b_stur1",  {11'b11111000000, 9'h001, 2'b00, 5'd7, 5'd9},
                     dt_word(5'd7, 5'd9, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 64'd1)};
        vecs[11] = '{"near_ldur",  {11'b11111000011, 9'h0FF, 2'b00, 5'd1, 5'd2}, 96'h0};
        vecs[12] = '{"zero_op",    32'h0000_0000, 96'h0};

        // Reset held while the clock runs and a legal LDUR is presented.
        rst_n = 1'b0;
        instr = 32'hF850_0004;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", 96'h0);

        // Release away from the clock edge; nothing appears before the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pre_first_edge", 96'h0);

        prev = 96'h0;
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].name, vecs[i].instr, vecs[i].exp, prev);
            prev = vecs[i].exp;
        end

        // Mid-stream reset must clear the output without a clock edge.
        apply("pre_reset_ldur", 32'hF850_0004,
              dt_word(5'd0, 5'd4, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, IMM_M256), prev);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", 96'h0);
        @(posedge clk);
        #1;
        check("reset_over_edge", 96'h0);

        // First word after release comes from the first rising edge.
        @(negedge clk);
        rst_n = 1'b1;
        apply("first_after_reset", 32'hF810_0008,
              dt_word(5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 2'b11, 2'b00, IMM_M256), 96'h0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
